// File: rtl/data_table_rd_arbiter_if.sv
// Data table RAM port: one read port with a fixed read latency, one write port.
// The read arbiter drives the read side; the write side is owned elsewhere.
interface data_table_if #(
    parameter int unsigned A_WIDTH = 10,
    parameter int unsigned D_WIDTH = 32
);
    logic               rd_en;
    logic [A_WIDTH-1:0] rd_addr;
    logic [D_WIDTH-1:0] rd_data;
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/data_table_rd_arbiter.sv
// Round-robin arbiter sharing the data table read port between CLIENTS_CNT clients.
// Every granted read is tagged so its data is flagged to the issuer RAM_LATENCY cycles later.
module data_table_rd_arbiter #(
    parameter int unsigned CLIENTS_CNT = 3,
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned A_WIDTH     = 10,
    localparam int unsigned IDX_W      = $clog2(CLIENTS_CNT),
    localparam int unsigned CNT_W      = $clog2(RAM_LATENCY + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [CLIENTS_CNT-1:0]              rd_req_i,
    input  logic [CLIENTS_CNT-1:0][A_WIDTH-1:0] rd_addr_i,
    output logic [CLIENTS_CNT-1:0]              rd_gnt_o,
    output logic [CLIENTS_CNT-1:0]              rd_data_val_o,
    output logic [CNT_W-1:0]                    in_flight_o,
    output logic                                idle_o,
    data_table_if.master                        data_table_if
);

    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   gnt_found;
    logic                   gnt_valid;
    logic [IDX_W-1:0]       gnt_idx;
    logic [RAM_LATENCY-1:0] vld_q;
    logic [IDX_W-1:0]       idx_q [RAM_LATENCY];

    // Search starts at the pointer and wraps modulo CLIENTS_CNT (not necessarily a power of 2).
    always_comb begin : p_arb
        int unsigned cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < CLIENTS_CNT; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= CLIENTS_CNT) begin
                cand = cand - CLIENTS_CNT;
            end
            if (!gnt_found && rd_req_i[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Nothing is honoured while reset is held.
    assign gnt_valid = gnt_found & ~rst_i;

    always_comb begin
        rd_gnt_o = '0;
        ptr_d    = ptr_q;
        if (gnt_valid) begin
            rd_gnt_o[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == IDX_W'(CLIENTS_CNT - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    assign data_table_if.rd_en   = gnt_valid;
    assign data_table_if.rd_addr = gnt_valid ? rd_addr_i[gnt_idx] : '0;
    assign data_table_if.wr_en   = 1'b0;
    assign data_table_if.wr_addr = 'x;
    assign data_table_if.wr_data = 'x;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= gnt_valid;
            idx_q[0] <= gnt_idx;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // The last tag stage lines up with rd_data leaving the RAM.
    always_comb begin
        rd_data_val_o = '0;
        if (vld_q[RAM_LATENCY-1]) begin
            rd_data_val_o[idx_q[RAM_LATENCY-1]] = 1'b1;
        end
    end

    always_comb begin
        in_flight_o = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            if (vld_q[i]) begin
                in_flight_o = in_flight_o + CNT_W'(1);
            end
        end
    end

    assign idle_o = ~(|rd_req_i) & ~(|vld_q);

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Bench for data_table_rd_arbiter: directed scenarios on a 3-client/latency-2 instance and
// a randomized scoreboard run on a 5-client/latency-3 instance, RAM returning data = address.
module tb_data_table_rd_arbiter;

    localparam int unsigned CA = 3;
    localparam int unsigned LA = 2;
    localparam int unsigned CB = 5;
    localparam int unsigned LB = 3;
    localparam int unsigned AW = 8;
    localparam int unsigned NRAND = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CA-1:0]         req_a;
    logic [CA-1:0][AW-1:0] addr_a;
    logic [CA-1:0]         gnt_a;
    logic [CA-1:0]         val_a;
    logic [1:0]            inf_a;
    logic                  idle_a;

    logic [CB-1:0]         req_b;
    logic [CB-1:0][AW-1:0] addr_b;
    logic [CB-1:0]         gnt_b;
    logic [CB-1:0]         val_b;
    logic [1:0]            inf_b;
    logic                  idle_b;

    data_table_if #(.A_WIDTH(AW), .D_WIDTH(AW)) ram_a ();
    data_table_if #(.A_WIDTH(AW), .D_WIDTH(AW)) ram_b ();

    data_table_rd_arbiter #(.CLIENTS_CNT(CA), .RAM_LATENCY(LA), .A_WIDTH(AW)) dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_req_i      (req_a),
        .rd_addr_i     (addr_a),
        .rd_gnt_o      (gnt_a),
        .rd_data_val_o (val_a),
        .in_flight_o   (inf_a),
        .idle_o        (idle_a),
        .data_table_if (ram_a)
    );

    data_table_rd_arbiter #(.CLIENTS_CNT(CB), .RAM_LATENCY(LB), .A_WIDTH(AW)) dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_req_i      (req_b),
        .rd_addr_i     (addr_b),
        .rd_gnt_o      (gnt_b),
        .rd_data_val_o (val_b),
        .in_flight_o   (inf_b),
        .idle_o        (idle_b),
        .data_table_if (ram_b)
    );

    // RAM models: data = address, valid RAM_LATENCY cycles after the read is issued.
    logic [AW-1:0] pipe_a [LA];
    logic [AW-1:0] pipe_b [LB];
    always @(posedge clk) begin
        pipe_a[0] <= ram_a.rd_addr;
        for (int i = 1; i < LA; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= ram_b.rd_addr;
        for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign ram_a.rd_data = pipe_a[LA-1];
    assign ram_b.rd_data = pipe_b[LB-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            k;
        logic [AW-1:0] addr;
    } ret_t;

    ret_t qa[$];
    ret_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        req_a  = '0;
        req_b  = '0;
        qa.delete();
        qb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_a  = '0;
        addr_a = '0;
        req_b  = '0;
        addr_b = '0;
        @(negedge clk);
        #1;
        n_chk++; if (gnt_a !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", gnt_a); end
        n_chk++; if (val_a !== '0) begin n_fail++; $display("FAIL reset_val: got %b want 000", val_a); end
        n_chk++; if (inf_a !== 2'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inf_a); end
        n_chk++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle_a); end
        n_chk++; if (ram_a.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", ram_a.rd_en); end
        n_chk++; if (ram_a.rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 00", ram_a.rd_addr); end
        // Requests raised during reset must not be granted.
        req_a = '1;
        req_b = '1;
        #1;
        n_chk++; if (gnt_a !== '0) begin n_fail++; $display("FAIL reset_req_gnt_a: got %b want 000", gnt_a); end
        n_chk++; if (gnt_b !== '0) begin n_fail++; $display("FAIL reset_req_gnt_b: got %b want 00000", gnt_b); end
        n_chk++; if (ram_a.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_req_rd_en: got %b want 0", ram_a.rd_en); end
        req_a = '0;
        req_b = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        // Pointer is 0 after reset; client 1 requests alone.
        @(negedge clk);
        req_a    = 3'b010;
        addr_a[1] = 8'h5A;
        #1;
        n_chk++; if (gnt_a !== 3'b010) begin n_fail++; $display("FAIL single_gnt: got %b want 010", gnt_a); end
        n_chk++; if (ram_a.rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en: got %b want 1", ram_a.rd_en); end
        n_chk++; if (ram_a.rd_addr !== 8'h5A) begin n_fail++; $display("FAIL single_rd_addr: got %h want 5a", ram_a.rd_addr); end
        n_chk++; if (idle_a !== 1'b0) begin n_fail++; $display("FAIL single_idle_req: got %b want 0", idle_a); end
        @(negedge clk);
        req_a = '0;
        #1;
        n_chk++; if (gnt_a !== '0) begin n_fail++; $display("FAIL single_gnt_off: got %b want 000", gnt_a); end
        n_chk++; if (ram_a.rd_addr !== '0) begin n_fail++; $display("FAIL single_addr_off: got %h want 00", ram_a.rd_addr); end
        n_chk++; if (inf_a !== 2'd1) begin n_fail++; $display("FAIL single_inflight_t1: got %0d want 1", inf_a); end
        n_chk++; if (val_a !== '0) begin n_fail++; $display("FAIL single_val_t1: got %b want 000", val_a); end
        n_chk++; if (idle_a !== 1'b0) begin n_fail++; $display("FAIL single_idle_t1: got %b want 0", idle_a); end
        @(negedge clk);
        #1;
        n_chk++; if (inf_a !== 2'd1) begin n_fail++; $display("FAIL single_inflight_t2: got %0d want 1", inf_a); end
        n_chk++; if (val_a !== 3'b010) begin n_fail++; $display("FAIL single_val_t2: got %b want 010", val_a); end
        n_chk++; if (ram_a.rd_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h want 5a", ram_a.rd_data); end
        @(negedge clk);
        #1;
        n_chk++; if (val_a !== '0) begin n_fail++; $display("FAIL single_val_t3: got %b want 000", val_a); end
        n_chk++; if (inf_a !== 2'd0) begin n_fail++; $display("FAIL single_inflight_t3: got %0d want 0", inf_a); end
        n_chk++; if (idle_a !== 1'b1) begin n_fail++; $display("FAIL single_idle_t3: got %b want 1", idle_a); end
    endtask

    task automatic test_all_continuous();
        logic [CA-1:0] exp_g;
        logic [CA-1:0] exp_v;
        logic [AW-1:0] exp_d;
        int            exp_inf;
        int            exp_k;
        ret_t          r;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_a = (i < 9) ? 3'b111 : 3'b000;
            for (int k = 0; k < CA; k++) addr_a[k] = AW'(16 * k + i);
            #1;
            exp_k   = (i < 9) ? (i % CA) : -1;
            exp_inf = qa.size();
            n_chk++; if (int'(inf_a) != exp_inf) begin n_fail++; $display("FAIL cont_inflight[%0d]: got %0d want %0d", i, inf_a, exp_inf); end
            exp_v = '0;
            exp_d = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                exp_v = CA'(1) << qa[0].k;
                exp_d = qa[0].addr;
                void'(qa.pop_front());
            end
            n_chk++; if (val_a !== exp_v) begin n_fail++; $display("FAIL cont_val[%0d]: got %b want %b", i, val_a, exp_v); end
            if (exp_v != '0) begin
                n_chk++; if (ram_a.rd_data !== exp_d) begin n_fail++; $display("FAIL cont_data[%0d]: got %h want %h", i, ram_a.rd_data, exp_d); end
            end
            exp_g = (exp_k >= 0) ? (CA'(1) << exp_k) : '0;
            n_chk++; if (gnt_a !== exp_g) begin n_fail++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, gnt_a, exp_g); end
            if (exp_k >= 0) begin
                n_chk++; if (ram_a.rd_addr !== addr_a[exp_k]) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h want %h", i, ram_a.rd_addr, addr_a[exp_k]); end
                r = '{due: cyc + LA, k: exp_k, addr: addr_a[exp_k]};
                qa.push_back(r);
            end
        end
    endtask

    task automatic test_two_clients();
        logic [CA-1:0] pat [7];
        int            seq [7];
        logic [CA-1:0] exp_g;
        logic [CA-1:0] exp_v;
        logic [AW-1:0] exp_d;
        ret_t          r;
        // Grant client 0 once to move the pointer to 1, then clients 0 and 2 contend.
        pat = '{3'b001, 3'b101, 3'b101, 3'b100, 3'b000, 3'b000, 3'b000};
        seq = '{0, 2, 0, 2, -1, -1, -1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_a = pat[i];
            for (int k = 0; k < CA; k++) addr_a[k] = AW'(8'h80 + 16 * k + i);
            #1;
            exp_v = '0;
            exp_d = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                exp_v = CA'(1) << qa[0].k;
                exp_d = qa[0].addr;
                void'(qa.pop_front());
            end
            n_chk++; if (val_a !== exp_v) begin n_fail++; $display("FAIL two_val[%0d]: got %b want %b", i, val_a, exp_v); end
            if (exp_v != '0) begin
                n_chk++; if (ram_a.rd_data !== exp_d) begin n_fail++; $display("FAIL two_data[%0d]: got %h want %h", i, ram_a.rd_data, exp_d); end
            end
            exp_g = (seq[i] >= 0) ? (CA'(1) << seq[i]) : '0;
            n_chk++; if (gnt_a !== exp_g) begin n_fail++; $display("FAIL two_gnt[%0d]: got %b want %b", i, gnt_a, exp_g); end
            if (seq[i] >= 0) begin
                r = '{due: cyc + LA, k: seq[i], addr: addr_a[seq[i]]};
                qa.push_back(r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CA-1:0] exp_g;
        logic [CA-1:0] exp_v;
        logic [AW-1:0] exp_d;
        int            pulses;
        ret_t          r;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_a = (i < 4) ? 3'b100 : 3'b000;
            for (int k = 0; k < CA; k++) addr_a[k] = AW'(8'hC0 + 16 * k + i);
            #1;
            exp_v = '0;
            exp_d = '0;
            if (qa.size() > 0 && qa[0].due == cyc) begin
                exp_v = CA'(1) << qa[0].k;
                exp_d = qa[0].addr;
                void'(qa.pop_front());
            end
            if (val_a[2] === 1'b1) pulses++;
            n_chk++; if (val_a !== exp_v) begin n_fail++; $display("FAIL b2b_val[%0d]: got %b want %b", i, val_a, exp_v); end
            if (exp_v != '0) begin
                n_chk++; if (ram_a.rd_data !== exp_d) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ram_a.rd_data, exp_d); end
            end
            exp_g = (i < 4) ? 3'b100 : 3'b000;
            n_chk++; if (gnt_a !== exp_g) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, gnt_a, exp_g); end
            if (i < 4) begin
                r = '{due: cyc + LA, k: 2, addr: addr_a[2]};
                qa.push_back(r);
            end
        end
        // Pulses for grants 0..3 land in iterations 2..5; all of them fall inside the loop.
        n_chk++; if (pulses != 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        @(negedge clk);
        req_b     = 5'b00001;
        addr_b[0] = 8'h11;
        #1;
        n_chk++; if (gnt_b !== 5'b00001) begin n_fail++; $display("FAIL rst_mid_gnt0: got %b want 00001", gnt_b); end
        @(negedge clk);
        req_b     = 5'b00010;
        addr_b[1] = 8'h22;
        #1;
        n_chk++; if (gnt_b !== 5'b00010) begin n_fail++; $display("FAIL rst_mid_gnt1: got %b want 00010", gnt_b); end
        @(negedge clk);
        req_b = '0;
        #1;
        n_chk++; if (inf_b !== 2'd2) begin n_fail++; $display("FAIL rst_mid_inflight_pre: got %0d want 2", inf_b); end
        rst = 1'b1;
        #1;
        n_chk++; if (inf_b !== 2'd0) begin n_fail++; $display("FAIL rst_mid_inflight_rst: got %0d want 0", inf_b); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_chk++; if (val_b !== '0) begin n_fail++; $display("FAIL rst_mid_dropped[%0d]: got %b want 00000", i, val_b); end
        end
        // Pointer back at 0: client 0 beats client 4.
        @(negedge clk);
        req_b     = 5'b10001;
        addr_b[0] = 8'h33;
        addr_b[4] = 8'h44;
        #1;
        n_chk++; if (gnt_b !== 5'b00001) begin n_fail++; $display("FAIL rst_mid_post_gnt: got %b want 00001", gnt_b); end
        n_chk++; if (ram_b.rd_addr !== 8'h33) begin n_fail++; $display("FAIL rst_mid_post_addr: got %h want 33", ram_b.rd_addr); end
        @(negedge clk);
        req_b = '0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (val_b !== 5'b00001) begin n_fail++; $display("FAIL rst_mid_post_val: got %b want 00001", val_b); end
        n_chk++; if (ram_b.rd_data !== 8'h33) begin n_fail++; $display("FAIL rst_mid_post_data: got %h want 33", ram_b.rd_data); end
    endtask

    task automatic test_random();
        logic [CB-1:0]   rq;
        logic [AW-1:0]   am [CB];
        logic [CB-1:0]   exp_g;
        logic [CB-1:0]   exp_v;
        logic [AW-1:0]   exp_d;
        int              ptr_m;
        int              exp_k;
        int              c;
        int              errs;
        ret_t            r;
        do_reset();
        rq    = '0;
        ptr_m = 0;
        errs  = 0;
        for (int k = 0; k < CB; k++) am[k] = '0;
        for (int i = 0; i < NRAND + 6; i++) begin
            @(negedge clk);
            for (int k = 0; k < CB; k++) begin
                if (i >= NRAND) begin
                    rq[k] = 1'b0;
                end else if (!rq[k] && $urandom_range(1, 0) == 1) begin
                    rq[k] = 1'b1;
                    am[k] = AW'($urandom);
                end
            end
            req_b = rq;
            for (int k = 0; k < CB; k++) addr_b[k] = am[k];
            #1;
            exp_k = -1;
            for (int j = 0; j < CB; j++) begin
                c = (ptr_m + j) % CB;
                if (exp_k < 0 && rq[c]) exp_k = c;
            end
            n_chk++; if (int'(inf_b) != qb.size()) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_inflight[%0d]: got %0d want %0d", i, inf_b, qb.size()); end
            exp_v = '0;
            exp_d = '0;
            if (qb.size() > 0 && qb[0].due == cyc) begin
                exp_v = CB'(1) << qb[0].k;
                exp_d = qb[0].addr;
                void'(qb.pop_front());
            end
            n_chk++; if (val_b !== exp_v) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_val[%0d]: got %b want %b", i, val_b, exp_v); end
            if (exp_v != '0) begin
                n_chk++; if (ram_b.rd_data !== exp_d) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_data[%0d]: got %h want %h", i, ram_b.rd_data, exp_d); end
            end
            exp_g = (exp_k >= 0) ? (CB'(1) << exp_k) : '0;
            n_chk++; if (gnt_b !== exp_g) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_gnt[%0d]: got %b want %b", i, gnt_b, exp_g); end
            if (exp_k >= 0) begin
                n_chk++; if (ram_b.rd_addr !== am[exp_k]) begin n_fail++; errs++; if (errs < 10) $display("FAIL rand_addr[%0d]: got %h want %h", i, ram_b.rd_addr, am[exp_k]); end
                r = '{due: cyc + LB, k: exp_k, addr: am[exp_k]};
                qb.push_back(r);
                ptr_m     = (exp_k + 1) % CB;
                rq[exp_k] = 1'($urandom_range(1, 0));
                am[exp_k] = AW'($urandom);
            end
        end
        n_chk++; if (qb.size() != 0) begin n_fail++; $display("FAIL rand_outstanding: got %0d want 0", qb.size()); end
        n_chk++; if (idle_b !== 1'b1) begin n_fail++; $display("FAIL rand_idle_end: got %b want 1", idle_b); end
    endtask

    initial begin
        req_a  = '0;
        addr_a = '0;
        req_b  = '0;
        addr_b = '0;
        test_reset();
        test_single();
        test_all_continuous();
        test_two_clients();
        test_back_to_back();
        n_chk++; if (qa.size() != 0) begin n_fail++; $display("FAIL directed_outstanding: got %0d want 0", qa.size()); end
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_table_rd_arbiter.md
# data_table_rd_arbiter

Round-robin arbiter that shares the single read port of the data table RAM between up to CLIENTS_CNT requesters (search engines, delete/insert engines). It grants one read per cycle, drives data_table_if, and tags every issued read so returned data is flagged valid to the issuing client exactly RAM_LATENCY cycles later. It replaces ad-hoc fixed-priority read muxing in front of the data table and guarantees starvation-free access.

## Interface
- CLIENTS_CNT, 3, number of read requesters; must be >= 2
- RAM_LATENCY, 2, cycles from rd_en to valid rd_data at the RAM; must be >= 1
- A_WIDTH, TABLE_ADDR_WIDTH, read address width
- clk_i  input  1  single clock, all logic rising-edge
- rst_i  input  1  reset, asynchronous, active-high
- rd_req_i  input  CLIENTS_CNT  per-client read request
- rd_addr_i  input  CLIENTS_CNT x A_WIDTH  per-client read address
- rd_gnt_o  output  CLIENTS_CNT  one-hot grant, combinational from rd_req_i and pointer
- rd_data_val_o  output  CLIENTS_CNT  one-hot: data_table_if.rd_data is valid for this client
- in_flight_o  output  $clog2(RAM_LATENCY+1)  reads issued and not yet returned
- idle_o  output  1  no request pending and in_flight_o == 0
- data_table_if  data_table_if.master  RAM port; rd_addr/rd_en driven, rd_data consumed; wr_en tied 0, wr_addr/wr_data 'x

## Operation
- Round-robin pointer ptr (width $clog2(CLIENTS_CNT)), reset 0.
- Each cycle: search clients ptr, ptr+1, ..., ptr+CLIENTS_CNT-1 (mod CLIENTS_CNT); first with rd_req_i set wins. At most one rd_gnt_o bit high; none if no request.
- On grant to client k: data_table_if.rd_en = 1, data_table_if.rd_addr = rd_addr_i[k]; ptr <= k+1, wrapping CLIENTS_CNT-1 -> 0 (no power-of-2 assumption).
- No grant: rd_en = 0, rd_addr = '0, ptr holds.
- Request protocol: client holds rd_req_i and rd_addr_i stable until it sees rd_gnt_o; a grant consumes exactly one read. Client may keep rd_req_i high for back-to-back reads; ptr rotation still applies, so a lone requester is granted every cycle.
- Return tagging: shift register of RAM_LATENCY stages, each {valid, client index}. Stage 0 loads {grant, k}; last stage drives rd_data_val_o[idx] = valid. rd_data is not registered: clients sample data_table_if.rd_data in the cycle their rd_data_val_o bit is high.
- in_flight_o = count of valid bits in the shift register; max RAM_LATENCY.
- Fairness: any continuously requesting client is granted within CLIENTS_CNT cycles.
- Reset asserted mid-operation: pointer to 0, shift register cleared, in-flight reads dropped (no rd_data_val_o for them); grant logic resumes first cycle after deassert.

## Timing
- Reset values: rd_gnt_o 0 (no requests are honoured during reset), rd_data_val_o 0, in_flight_o 0, idle_o 1, data_table_if.rd_en 0, rd_addr 0.
- Grant latency 0: rd_req_i high in cycle T with winning priority -> rd_gnt_o and rd_en in T.
- Data latency: grant in T -> rd_data_val_o[k] high in T+RAM_LATENCY, exactly one cycle per grant.
- Throughput: one read per cycle total; returns pipelined, ordering follows grant order.
- Simultaneous grant and return in same cycle: both happen; in_flight_o unchanged net.
- Pointer and shift register are the only state; no backpressure on returns (clients must accept data when flagged).

## Test plan
- Single client 1 requests once at cycle 5 (RAM_LATENCY=2) -> rd_gnt_o=3'b010 and rd_en at 5, rd_addr = its address; rd_data_val_o=3'b010 at 7, in_flight_o 1 at 6-7, idle_o 1 at 8.
- All 3 clients request continuously from reset -> grants 0,1,2,0,1,2...; rd_data_val_o follows same sequence delayed 2 cycles; in_flight_o saturates at 2.
- Clients 0 and 2 request, client 1 idle, ptr=1 -> grant 2 first, then 0, then 2; ptr values 0,1,0 observed after each grant.
- Only client 2 requests back-to-back 4 cycles -> granted every cycle, ptr wraps 2->0 each time, four consecutive rd_data_val_o[2] pulses.
- Reset asserted one cycle after two grants issued -> no rd_data_val_o pulse for them, in_flight_o 0, ptr 0; first post-reset request granted normally.
- RAM model returns data=address: every rd_data_val_o[k] pulse carries rd_addr_i[k] of its grant; scoreboard checks order and zero spurious pulses over 10k random requests with CLIENTS_CNT=5, RAM_LATENCY=3.
